// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter unit.
package pc_pkg;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_TRAP = 1'b1
    } pc_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_EXC  = 2'd1,
        CAUSE_IRQ  = 2'd2
    } pc_cause_e;

    localparam int          DEFAULT_XLEN      = 32;
    localparam int          DEFAULT_INC       = 4;
    localparam logic [31:0] DEFAULT_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] DEFAULT_EXC_VEC   = 32'h8000_0004;
    localparam logic [31:0] DEFAULT_IRQ_VEC   = 32'h8000_0008;

endpackage

// File: rtl/pc_irq_latch.sv
// Interrupt rising-edge detector with a single pending bit; present only when PC_IRQ_EN is defined.
module pc_irq_latch (
    input  logic clk,
    input  logic reset_n,
    input  logic irq,
    input  logic service,
    output logic irq_pending
);

    logic irq_q;
    logic pending_q;
    logic irq_rise;

    assign irq_rise = irq & ~irq_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            irq_q <= irq;
            // A fresh edge wins over service so a back-to-back request is never lost.
            if (irq_rise)
                pending_q <= 1'b1;
            else if (service)
                pending_q <= 1'b0;
        end
    end

    assign irq_pending = pending_q;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch, branch/stall, exception and interrupt traps, eret.
// Interrupt support is built only when the macro PC_IRQ_EN is defined.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = DEFAULT_XLEN,
    parameter int              INC       = DEFAULT_INC,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
    parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(DEFAULT_EXC_VEC),
    parameter logic [XLEN-1:0] IRQ_VEC   = XLEN'(DEFAULT_IRQ_VEC)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            branch_en,
    input  logic [XLEN-1:0] branch_target,
    input  logic            exception,
    input  logic            irq,
    input  logic            eret,
    output logic [XLEN-1:0] ia,
    output logic [XLEN-1:0] epc,
    output logic            in_trap,
    output logic            irq_pending,
    output logic [1:0]      cause
);

    pc_state_e       state_q, state_d;
    pc_cause_e       cause_q, cause_d;
    logic [XLEN-1:0] ia_q, ia_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            pending;
    logic            irq_take;
    logic [1:0]      unused_target_lsb;

    assign unused_target_lsb = branch_target[1:0];

`ifdef PC_IRQ_EN
    pc_irq_latch u_irq_latch (
        .clk         (clk),
        .reset_n     (reset_n),
        .irq         (irq),
        .service     (irq_take),
        .irq_pending (pending)
    );
`else
    logic            unused_irq;
    logic [XLEN-1:0] unused_irq_vec;

    assign pending        = 1'b0;
    assign unused_irq     = irq;
    assign unused_irq_vec = IRQ_VEC;
`endif

    // An exception in the same cycle keeps the interrupt pending for later.
    assign irq_take = pending && (state_q == PC_RUN) && !exception;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        ia_d    = ia_q + XLEN'(INC);

        if (exception) begin
            epc_d   = ia_q;
            ia_d    = EXC_VEC;
            cause_d = CAUSE_EXC;
            state_d = PC_TRAP;
        end else if (irq_take) begin
            epc_d   = ia_q;
            ia_d    = IRQ_VEC;
            cause_d = CAUSE_IRQ;
            state_d = PC_TRAP;
        end else if (eret && (state_q == PC_TRAP)) begin
            ia_d    = epc_q;
            state_d = PC_RUN;
        end else if (branch_en) begin
            ia_d = {branch_target[XLEN-1:2], 2'b00};
        end else if (stall) begin
            ia_d = ia_q;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the same pre-edge values.
        if (!reset_n) begin
            state_q <= PC_RUN;
            cause_q <= CAUSE_NONE;
            ia_q    <= RESET_VEC;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            ia_q    <= ia_d;
            epc_q   <= epc_d;
        end
    end

    assign ia          = ia_q;
    assign epc         = epc_q;
    assign in_trap     = (state_q == PC_TRAP);
    assign irq_pending = pending;
    assign cause       = cause_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_pc_unit;

`ifdef PC_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    localparam logic [31:0] RST_V = 32'h8000_0000;
    localparam logic [31:0] EXC_V = 32'h8000_0004;
    localparam logic [31:0] IRQ_V = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset_n, stall, branch_en, exception, irq, eret;
    logic [31:0] branch_target;
    logic [31:0] ia, epc;
    logic        in_trap, irq_pending;
    logic [1:0]  cause;

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural model of the architectural state.
    logic [31:0] m_ia = '0, m_epc = '0;
    logic [1:0]  m_cause = '0;
    logic        m_trap = 1'b0, m_pend = 1'b0, m_irq_prev = 1'b0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .exception     (exception),
        .irq           (irq),
        .eret          (eret),
        .ia            (ia),
        .epc           (epc),
        .in_trap       (in_trap),
        .irq_pending   (irq_pending),
        .cause         (cause)
    );

    task automatic model_update();
        logic took_irq;
        logic rise;
        took_irq = 1'b0;
        rise     = irq && !m_irq_prev;
        if (!reset_n) begin
            m_ia = RST_V; m_epc = '0; m_cause = 2'd0; m_trap = 1'b0;
            m_pend = 1'b0; m_irq_prev = 1'b0;
        end else begin
            if (exception) begin
                m_epc = m_ia; m_ia = EXC_V; m_cause = 2'd1; m_trap = 1'b1;
            end else if (IRQ_EN && m_pend && !m_trap) begin
                m_epc = m_ia; m_ia = IRQ_V; m_cause = 2'd2; m_trap = 1'b1;
                took_irq = 1'b1;
            end else if (eret && m_trap) begin
                m_ia = m_epc; m_trap = 1'b0;
            end else if (branch_en) begin
                m_ia = branch_target & 32'hFFFF_FFFC;
            end else if (!stall) begin
                m_ia = m_ia + 32'd4;
            end
            if (!IRQ_EN)       m_pend = 1'b0;
            else if (rise)     m_pend = 1'b1;
            else if (took_irq) m_pend = 1'b0;
            m_irq_prev = irq;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        reset_n = 1'b1; stall = 1'b0; branch_en = 1'b0; exception = 1'b0;
        eret = 1'b0; irq = 1'b0; branch_target = '0;
    endtask

    task automatic do_reset();
        set_idle();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        reset_n = 1'b0;
        step();
        step();
        n_vec++;
        if ({ia, epc, in_trap, irq_pending, cause} !== {RST_V, 32'h0, 1'b0, 1'b0, 2'd0}) begin
            n_miss++;
            $display("FAIL reset_state: got ia=%h epc=%h trap=%b pend=%b cause=%0d, want ia=%h epc=0 trap=0 pend=0 cause=0",
                     ia, epc, in_trap, irq_pending, cause, RST_V);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_vec++;
            if (ia !== RST_V + 32'(4 * i)) begin
                n_miss++;
                $display("FAIL seq_inc_%0d: got ia=%h, want %h", i, ia, RST_V + 32'(4 * i));
            end
        end
    endtask

    task automatic test_branch_stall();
        do_reset();
        step();
        n_vec++;
        if (ia !== 32'h8000_0004) begin
            n_miss++;
            $display("FAIL pre_branch: got ia=%h, want 80000004", ia);
        end
        branch_en = 1'b1; branch_target = 32'h0000_1003;
        step();
        n_vec++;
        if (ia !== 32'h0000_1000) begin
            n_miss++;
            $display("FAIL branch_align: got ia=%h, want 00001000", ia);
        end
        branch_en = 1'b0; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (ia !== 32'h0000_1000) begin
                n_miss++;
                $display("FAIL stall_hold_%0d: got ia=%h, want 00001000", i, ia);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_exception();
        exception = 1'b1;
        step();
        exception = 1'b0;
        n_vec++;
        if ({ia, epc, cause, in_trap} !== {EXC_V, 32'h0000_1000, 2'd1, 1'b1}) begin
            n_miss++;
            $display("FAIL exc_entry: got ia=%h epc=%h cause=%0d trap=%b, want ia=%h epc=00001000 cause=1 trap=1",
                     ia, epc, cause, in_trap, EXC_V);
        end
        eret = 1'b1;
        step();
        eret = 1'b0;
        n_vec++;
        if ({ia, in_trap, cause} !== {32'h0000_1000, 1'b0, 2'd1}) begin
            n_miss++;
            $display("FAIL exc_eret: got ia=%h trap=%b cause=%0d, want ia=00001000 trap=0 cause=1",
                     ia, in_trap, cause);
        end
    endtask

    task automatic test_irq_in_trap();
        do_reset();
        branch_en = 1'b1; branch_target = 32'h0000_2000;
        step();
        branch_en = 1'b0; exception = 1'b1;
        step();
        exception = 1'b0; irq = 1'b1; stall = 1'b1;
        step();
        n_vec++;
        if ({irq_pending, ia, in_trap} !== {IRQ_EN, EXC_V, 1'b1}) begin
            n_miss++;
            $display("FAIL irq_pend_in_trap: got pend=%b ia=%h trap=%b, want pend=%b ia=%h trap=1",
                     irq_pending, ia, in_trap, IRQ_EN, EXC_V);
        end
        irq = 1'b0;
        step();
        stall = 1'b0; eret = 1'b1;
        step();
        eret = 1'b0;
        n_vec++;
        if ({ia, in_trap, irq_pending} !== {32'h0000_2000, 1'b0, IRQ_EN}) begin
            n_miss++;
            $display("FAIL eret_with_pend: got ia=%h trap=%b pend=%b, want ia=00002000 trap=0 pend=%b",
                     ia, in_trap, irq_pending, IRQ_EN);
        end
        step();
        n_vec++;
        if ({ia, epc, cause, in_trap, irq_pending} !==
            {(IRQ_EN ? IRQ_V : 32'h0000_2004), 32'h0000_2000, (IRQ_EN ? 2'd2 : 2'd1), IRQ_EN, 1'b0}) begin
            n_miss++;
            $display("FAIL irq_taken: got ia=%h epc=%h cause=%0d trap=%b pend=%b, want ia=%h epc=00002000 cause=%0d trap=%b pend=0",
                     ia, epc, cause, in_trap, irq_pending, (IRQ_EN ? IRQ_V : 32'h0000_2004),
                     (IRQ_EN ? 2'd2 : 2'd1), IRQ_EN);
        end
    endtask

    task automatic test_edge_during_service();
        do_reset();
        exception = 1'b1;
        step();
        exception = 1'b0; irq = 1'b1; stall = 1'b1;
        step();
        irq = 1'b0;
        step();
        stall = 1'b0; eret = 1'b1;
        step();
        eret = 1'b0; irq = 1'b1;
        step();
        irq = 1'b0;
        n_vec++;
        if ({irq_pending, cause, in_trap} !== {IRQ_EN, (IRQ_EN ? 2'd2 : 2'd1), IRQ_EN}) begin
            n_miss++;
            $display("FAIL edge_at_service: got pend=%b cause=%0d trap=%b, want pend=%b cause=%0d trap=%b",
                     irq_pending, cause, in_trap, IRQ_EN, (IRQ_EN ? 2'd2 : 2'd1), IRQ_EN);
        end
    endtask

    task automatic test_priority_wrap();
        do_reset();
        exception = 1'b1; stall = 1'b1; branch_en = 1'b1; branch_target = 32'h0000_5555;
        step();
        exception = 1'b0;
        n_vec++;
        if (ia !== EXC_V) begin
            n_miss++;
            $display("FAIL exc_over_branch_stall: got ia=%h, want %h", ia, EXC_V);
        end
        eret = 1'b1;
        step();
        n_vec++;
        if ({ia, in_trap} !== {RST_V, 1'b0}) begin
            n_miss++;
            $display("FAIL eret_over_branch_stall: got ia=%h trap=%b, want ia=%h trap=0", ia, in_trap, RST_V);
        end
        stall = 1'b0;
        step();
        n_vec++;
        if (ia !== 32'h0000_5554) begin
            n_miss++;
            $display("FAIL eret_ignored_in_run: got ia=%h, want 00005554", ia);
        end
        eret = 1'b0; branch_target = 32'hFFFF_FFFF;
        step();
        branch_en = 1'b0;
        n_vec++;
        if (ia !== 32'hFFFF_FFFC) begin
            n_miss++;
            $display("FAIL branch_top: got ia=%h, want fffffffc", ia);
        end
        step();
        n_vec++;
        if (ia !== 32'h0000_0000) begin
            n_miss++;
            $display("FAIL wrap: got ia=%h, want 00000000", ia);
        end
    endtask

    task automatic test_reset_in_trap();
        do_reset();
        exception = 1'b1;
        step();
        exception = 1'b0; irq = 1'b1; stall = 1'b1;
        step();
        n_vec++;
        if ({in_trap, irq_pending} !== {1'b1, IRQ_EN}) begin
            n_miss++;
            $display("FAIL trap_before_reset: got trap=%b pend=%b, want trap=1 pend=%b", in_trap, irq_pending, IRQ_EN);
        end
        irq = 1'b0; reset_n = 1'b0;
        step();
        n_vec++;
        if ({ia, epc, in_trap, irq_pending, cause} !== {RST_V, 32'h0, 1'b0, 1'b0, 2'd0}) begin
            n_miss++;
            $display("FAIL reset_mid_trap: got ia=%h epc=%h trap=%b pend=%b cause=%0d, want ia=%h epc=0 trap=0 pend=0 cause=0",
                     ia, epc, in_trap, irq_pending, cause, RST_V);
        end
        set_idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset_n       = ($urandom_range(0, 199) != 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_en     = ($urandom_range(0, 6) == 0);
            exception     = ($urandom_range(0, 19) == 0);
            eret          = ($urandom_range(0, 4) == 0);
            branch_target = $urandom;
            if ($urandom_range(0, 4) == 0) irq = ~irq;
            step();
            n_vec++;
            if ({ia, epc, in_trap, irq_pending, cause} !== {m_ia, m_epc, m_trap, m_pend, m_cause}) begin
                n_miss++;
                $display("FAIL random_%0d: got ia=%h epc=%h trap=%b pend=%b cause=%0d, want ia=%h epc=%h trap=%b pend=%b cause=%0d",
                         i, ia, epc, in_trap, irq_pending, cause, m_ia, m_epc, m_trap, m_pend, m_cause);
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_branch_stall();
        test_exception();
        test_irq_in_trap();
        test_edge_during_service();
        test_priority_wrap();
        test_reset_in_trap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle/pipelined core; it supplies the instruction address `ia` to instruction memory each cycle. It generalises the basic sequential-increment PC with:

- configurable width, vectors and increment;
- branch redirect and stall;
- a latched interrupt request;
- an exception PC (`epc`) register;
- a two-state run/trap machine with return-from-trap.

All state changes are synchronous to `clk`.

## Interface
Parameters:
- `XLEN`, 32: address width.
- `INC`, 4: sequential increment in bytes.
- `RESET_VEC`, 32'h8000_0000: `ia` after reset.
- `EXC_VEC`, 32'h8000_0004: exception handler entry.
- `IRQ_VEC`, 32'h8000_0008: interrupt handler entry.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hold `ia` this cycle.
- `branch_en`  in  1  redirect to `branch_target`.
- `branch_target`  in  XLEN  redirect address.
- `exception`  in  1  synchronous exception for instruction at `ia`.
- `irq`  in  1  external interrupt request, level, synchronous to `clk`.
- `eret`  in  1  return from trap to `epc`.
- `ia`  out  XLEN  current instruction address.
- `epc`  out  XLEN  saved return address.
- `in_trap`  out  1  1 while in state TRAP.
- `irq_pending`  out  1  latched, unserviced interrupt.
- `cause`  out  2  last trap cause: 0 none, 1 exception, 2 irq.

## Operation
States: RUN (`in_trap`=0) and TRAP (`in_trap`=1).

Next-`ia` priority, highest first:
1. `!reset_n`: `ia`=RESET_VEC, `epc`=0, `cause`=0, state RUN, `irq_pending`=0.
2. `exception`: `epc`<=`ia`, `ia`<=EXC_VEC, `cause`<=1, state TRAP. Legal in TRAP (nested): `epc` is overwritten.
3. `irq_pending` && state RUN: `epc`<=`ia`, `ia`<=IRQ_VEC, `cause`<=2, `irq_pending`<=0, state TRAP.
4. `eret` && state TRAP: `ia`<=`epc`, state RUN; `cause` unchanged. `eret` in RUN is ignored; the lower-priority sources below then apply.
5. `branch_en`: `ia`<={`branch_target`[XLEN-1:2],2'b00}.
6. `stall`: `ia` holds.
7. Otherwise: `ia`<=`ia`+INC, modulo 2^XLEN (all-ones minus 3 wraps to 0).

Priority rules:
- Traps (2, 3) override `stall` and `branch_en`.
- `eret` overrides `branch_en` and `stall`.

Interrupt latch:
- A 0->1 transition of `irq` (registered previous value vs current) sets `irq_pending`.
- `irq_pending` stays set while in TRAP; it is serviced in the first RUN cycle.
- A further edge while pending is absorbed, with no count.
- Edge and service in the same cycle: the pending bit stays 1, so the new edge is retained.

## Timing
- One-cycle latency for every redirect: a source asserted in cycle N gives the new `ia` in cycle N+1.
- `irq` edge in cycle N: `irq_pending`=1 in N+1; `ia`=IRQ_VEC in N+2 if RUN.
- `eret` and pending irq in the same cycle: `eret` applies, giving `ia`=`epc` and RUN in N+1; the irq is taken in N+1, giving `ia`=IRQ_VEC in N+2 and `epc`= the returned address.
- Reset mid-trap: all state is cleared in one cycle; `ia`=RESET_VEC in the next cycle.
- Outputs are registered only; there is no combinational input-to-output path.

## Configuration
`PC_IRQ_EN`:
- Defined: interrupt edge detect, pending latch and IRQ_VEC entry are present.
- Undefined: `irq` is ignored, `irq_pending` is tied to 0, `cause` never equals 2, and the edge register is not built.

## Structure
- Package `pc_pkg`:
  - enum `pc_state_e` {PC_RUN, PC_TRAP};
  - enum `pc_cause_e` {CAUSE_NONE=0, CAUSE_EXC=1, CAUSE_IRQ=2};
  - default vector localparams.
- One sub-module, `pc_irq_latch`: edge detect plus pending set/clear, taking a `service` input. It is instantiated only under `PC_IRQ_EN`.

## Test plan
Defaults are XLEN=32, `PC_IRQ_EN` defined.
- Reset low 2 cycles, then idle 3 cycles -> `ia` 8000_0000, 8000_0004, 8000_0008, 8000_000C.
- `branch_en` with target 0000_1003 at `ia`=8000_0004 -> next `ia`=0000_1000; `stall` for 2 cycles -> `ia` held at 0000_1000.
- `exception` at `ia`=0000_1000 -> `ia`=8000_0004, `epc`=0000_1000, `cause`=1, `in_trap`=1; `eret` -> `ia`=0000_1000, `in_trap`=0.
- `irq` rises while in TRAP -> `irq_pending`=1 with no redirect; `eret` with `epc`=0000_2000 -> `ia`=0000_2000, then 8000_0008 with `epc`=0000_2000 and `cause`=2.
- `exception` and `stall` and `branch_en` in the same cycle -> `ia`=8000_0004; `ia`=FFFF_FFFC idle -> 0000_0000.
- Reset asserted while in TRAP with `irq_pending`=1 -> `ia`=8000_0000, `in_trap`=0, `irq_pending`=0, `epc`=0.
